// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state type, counter widths and window indexing for conv_window_gen
package conv_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_IMG_W  = 8;
    localparam int DEF_IMG_H  = 8;
    localparam int DEF_K      = 3;

    localparam int COL_W = $clog2(DEF_IMG_W);
    localparam int ROW_W = $clog2(DEF_IMG_H);

    typedef enum logic [0:0] {
        FILL   = 1'b0,
        STREAM = 1'b1
    } conv_state_e;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Element (r,c) of a packed KxK window; r=0 is the oldest row, c=0 the leftmost column.
    function automatic int win_off(input int r, input int c, input int k, input int dw);
        return (r * k + c) * dw;
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// rtl/conv_line_buf.sv - RAM delay line of DEPTH accepted samples for one window row
module conv_line_buf
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_IMG_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              shift_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int PW = cnt_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     ptr;

    // Read-before-write at the pointer yields the sample written DEPTH shifts ago.
    assign dout = mem[ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (shift_en) begin
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (shift_en) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - streaming KxK valid-convolution window generator
// Optional frame_count output enabled by CONV_WINDOW_GEN_FRAME_CNT_EN.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int K      = DEF_K
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [K*K*DATA_W-1:0] out_window,
    output logic                  frame_done
`ifdef CONV_WINDOW_GEN_FRAME_CNT_EN
    ,
    output logic [15:0]           frame_count
`endif
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
    localparam int WW = K * K * DATA_W;

    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    conv_state_e       state;
    logic [WW-1:0]     win;
    logic [WW-1:0]     win_next;
    logic [DATA_W-1:0] lb_out  [K-1];
    logic [DATA_W-1:0] row_new [K];
    logic              acc;
    logic              emit;
    logic              col_last;
    logic              row_last;
    logic              frame_last;

    assign in_ready   = !out_valid || out_ready;
    assign acc        = in_valid && in_ready;
    assign col_last   = (col == CW'(IMG_W - 1));
    assign row_last   = (row == RW'(IMG_H - 1));
    assign frame_last = col_last && row_last;
    assign emit       = acc && (state == STREAM) && (col >= CW'(K - 1));

    assign row_new[K-1] = in_data;

    // Buffer K-2 is fed by the live pixel; each older row is fed by the row below it.
    for (genvar r = 0; r < K - 1; r++) begin : g_lb
        logic [DATA_W-1:0] lb_in;
        if (r == K - 2) begin : g_head
            assign lb_in = in_data;
        end else begin : g_tail
            assign lb_in = lb_out[r+1];
        end

        conv_line_buf #(
            .DATA_W(DATA_W),
            .DEPTH (IMG_W)
        ) u_lb (
            .clock   (clock),
            .reset   (reset),
            .shift_en(acc),
            .din     (lb_in),
            .dout    (lb_out[r])
        );

        assign row_new[r] = lb_out[r];
    end

    always_comb begin
        win_next = win;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                if (c < K - 1) begin
                    win_next[win_off(r, c, K, DATA_W) +: DATA_W] = win[win_off(r, c + 1, K, DATA_W) +: DATA_W];
                end else begin
                    win_next[win_off(r, c, K, DATA_W) +: DATA_W] = row_new[r];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            col   <= '0;
            row   <= '0;
            state <= FILL;
            win   <= '0;
        end else if (acc) begin
            win <= win_next;
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
            if (state == FILL && col_last && row == RW'(K - 2)) begin
                state <= STREAM;
            end else if (state == STREAM && frame_last) begin
                state <= FILL;
            end
        end
    end

    // A new emit reloads the register even while the old window is being taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_window <= '0;
            frame_done <= 1'b0;
        end else if (emit) begin
            out_valid  <= 1'b1;
            out_window <= win_next;
            frame_done <= frame_last;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
        end
    end

`ifdef CONV_WINDOW_GEN_FRAME_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count <= '0;
        end else if (acc && frame_last) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - randomized self-checking bench for conv_window_gen against a frame-array model
module tb_conv_window_gen;

    localparam int DW = 8;
    localparam int IW = 4;
    localparam int IH = 4;
    localparam int K  = 3;
    localparam int WW = K * K * DW;
    localparam int N  = IW * IH;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [WW-1:0] out_window;
    logic          frame_done;
`ifdef CONV_WINDOW_GEN_FRAME_CNT_EN
    logic [15:0]   frame_count;
`endif

    conv_window_gen #(
        .DATA_W(DW),
        .IMG_W (IW),
        .IMG_H (IH),
        .K     (K)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_window(out_window),
        .frame_done(frame_done)
`ifdef CONV_WINDOW_GEN_FRAME_CNT_EN
        ,
        .frame_count(frame_count)
`endif
    );

    always #5 clock = ~clock;

    // Model: current frame kept as a flat array indexed by raster position.
    logic [DW-1:0] img [N];
    int            m_p = 0;
    logic          m_valid = 1'b0;
    logic [WW-1:0] m_win = '0;
    logic          m_fd = 1'b0;
    logic [15:0]   m_fcnt = '0;

    always @(posedge clock) begin : model
        logic          acc_m;
        logic          last_m;
        int            rw;
        int            cl;
        int            pr;
        int            pc;
        logic [WW-1:0] w;
        if (reset) begin
            m_p     <= 0;
            m_valid <= 1'b0;
            m_win   <= '0;
            m_fd    <= 1'b0;
            m_fcnt  <= '0;
        end else begin
            acc_m  = in_valid && (!m_valid || out_ready);
            rw     = m_p / IW;
            cl     = m_p % IW;
            last_m = (m_p == N - 1);
            w      = '0;
            if (acc_m) begin
                img[m_p] <= in_data;
                m_p      <= last_m ? 0 : m_p + 1;
                if (last_m) m_fcnt <= m_fcnt + 16'd1;
            end
            if (acc_m && rw >= K - 1 && cl >= K - 1) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        pr = rw - (K - 1) + r;
                        pc = cl - (K - 1) + c;
                        w[(r * K + c) * DW +: DW] = (r == K - 1 && c == K - 1) ? in_data : img[pr * IW + pc];
                    end
                end
                m_valid <= 1'b1;
                m_win   <= w;
                m_fd    <= last_m;
            end else if (out_ready) begin
                m_valid <= 1'b0;
                m_fd    <= 1'b0;
            end
        end
    end

    int            n_cmp = 0;
    int            n_bad = 0;
    logic          started = 1'b0;
    int            dut_acc_cnt = 0;
    logic [WW-1:0] win_log [$];
    logic          fd_log  [$];

    task automatic chk(input string nm, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] mk(input int e [9]);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < 9; i++) w[i * DW +: DW] = e[i][DW-1:0];
        return w;
    endfunction

    task automatic send(input logic [DW-1:0] d, input int gap_pct);
        logic ok;
        int   n;
        while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            @(posedge clock); #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clock);
            ok = in_ready;
            @(posedge clock); #1;
            n++;
        end
        if (!ok) chk("send_timeout", 1, 0);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (4) @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lit [9];
        int  base;
        int  acc0;
        int  n;
        logic stop;

        fork
            forever begin
                @(negedge clock);
                if (started && !reset) begin
                    chk("in_ready", in_ready, !m_valid || out_ready);
                    chk("out_valid", out_valid, m_valid);
                    if (m_valid) begin
                        chk("out_window", out_window, m_win);
                        chk("frame_done", frame_done, m_fd);
                    end
`ifdef CONV_WINDOW_GEN_FRAME_CNT_EN
                    chk("frame_count", frame_count, m_fcnt);
`endif
                    if (out_valid && out_ready) begin
                        win_log.push_back(out_window);
                        fd_log.push_back(frame_done);
                    end
                    if (in_valid && in_ready) dut_acc_cnt++;
                end
            end
        join_none

        repeat (2) @(posedge clock);
        #1;
        reset   = 1'b0;
        started = 1'b1;
        @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_window", out_window, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clock); #1;

        // 1: one frame, continuous input
        base = win_log.size();
        for (int i = 0; i < N; i++) send(DW'(i), 0);
        drain();
        chk("s1_count", win_log.size() - base, 4);
        lit = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        chk("s1_first", win_log[base], mk(lit));
        lit = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        chk("s1_second", win_log[base+1], mk(lit));
        lit = '{4, 5, 6, 8, 9, 10, 12, 13, 14};
        chk("s1_third", win_log[base+2], mk(lit));
        lit = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        chk("s1_last", win_log[base+3], mk(lit));
        chk("s1_fd_last", fd_log[base+3], 1);
        chk("s1_fd_first", fd_log[base], 0);

        // 2: stall the first window for 5 cycles
        do_reset();
        base      = win_log.size();
        acc0      = dut_acc_cnt;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < N; i++) send(DW'(i), 0);
            end
            begin
                n = 0;
                while (!out_valid && n < 100) begin
                    @(negedge clock);
                    n++;
                end
                if (!out_valid) chk("s2_wait_window", 0, 1);
                lit = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
                for (int i = 0; i < 5; i++) begin
                    if (i > 0) @(negedge clock);
                    chk("s2_in_ready_low", in_ready, 0);
                    chk("s2_held_window", out_window, mk(lit));
                end
                chk("s2_consumed", dut_acc_cnt - acc0, 11);
                @(posedge clock); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("s2_count", win_log.size() - base, 4);
        lit = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        chk("s2_second", win_log[base+1], mk(lit));

        // 3: two frames back to back
        do_reset();
        base = win_log.size();
        for (int i = 0; i < 2 * N; i++) send(DW'(i), 0);
        drain();
        chk("s3_count", win_log.size() - base, 8);
        lit = '{16, 17, 18, 20, 21, 22, 24, 25, 26};
        chk("s3_f2_first", win_log[base+4], mk(lit));
        chk("s3_fd4", fd_log[base+3], 1);
        chk("s3_fd8", fd_log[base+7], 1);
        chk("s3_fd5", fd_log[base+4], 0);

        // 4: random input gaps
        do_reset();
        base = win_log.size();
        for (int i = 0; i < N; i++) send(DW'(i), 50);
        drain();
        chk("s4_count", win_log.size() - base, 4);
        lit = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        chk("s4_first", win_log[base], mk(lit));
        lit = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        chk("s4_last", win_log[base+3], mk(lit));

        // 5: reset after pixel 9
        do_reset();
        for (int i = 0; i < 10; i++) send(DW'(i), 0);
        do_reset();
        base = win_log.size();
        for (int i = 0; i < N; i++) send(DW'(100 + i), 0);
        drain();
        chk("s5_count", win_log.size() - base, 4);
        lit = '{100, 101, 102, 104, 105, 106, 108, 109, 110};
        chk("s5_first", win_log[base], mk(lit));

        // 7: random data, random gaps and random backpressure over three frames
        do_reset();
        base = win_log.size();
        stop = 1'b0;
        fork
            begin
                for (int i = 0; i < 3 * N; i++) send(DW'($urandom_range(255)), 30);
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    @(posedge clock); #1;
                    out_ready = ($urandom_range(1) == 1);
                end
            end
        join
        drain();
        chk("s7_count", win_log.size() - base, 12);

`ifdef CONV_WINDOW_GEN_FRAME_CNT_EN
        // 6: frame counter over three frames and reset
        do_reset();
        chk("s6_fc_reset", frame_count, 0);
        for (int f = 1; f <= 3; f++) begin
            for (int i = 0; i < N; i++) send(DW'(i), 20);
            drain();
            chk("s6_fc_step", frame_count, f);
        end
        do_reset();
        chk("s6_fc_cleared", frame_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming sliding-window generator for the convolution datapath.
- Accepts a raster-order pixel stream, one pixel per accepted beat.
- Delays rows through K-1 line buffers, each IMG_W deep, and emits a full KxK window for the multiply stage.
- Emits a window only when it lies fully inside the image: valid convolution, no padding, stride 1.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 8, image width in pixels; must be >= K.
- IMG_H, 8, image height in pixels; must be >= K.
- K, 3, window edge length; must be >= 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data holds a pixel.
- in_data  in  DATA_W  pixel, raster order.
- in_ready  out  1  block can accept a pixel this cycle.
- out_valid  out  1  out_window holds a valid window.
- out_ready  in  1  downstream takes the window this cycle.
- out_window  out  K*K*DATA_W  packed window.
- frame_done  out  1  qualifies the last window of a frame.

Behaviour:
- Single clock domain; reset is synchronous, active-high.
- Reset values: out_valid=0, out_window=0, frame_done=0, col=0, row=0, state=FILL, window registers=0.
  - in_ready=1 after reset (combinational, see below).
  - Line-buffer RAM contents are not cleared.
- Accept condition: acc = in_valid && in_ready, where in_ready = !out_valid || out_ready (one-deep output register).
- On acc:
  - Every window row shifts left by one.
  - Bottom row takes in_data.
  - Row r (r < K-1) takes the output of line buffer r.
  - Line buffers advance by one only on acc. No advance and no RAM write when acc=0.
- Window packing:
  - Element (r,c) sits at bits [(r*K+c)*DATA_W +: DATA_W].
  - r=0 is the oldest row, c=0 is the leftmost column.
  - Element (K-1,K-1) is the newest pixel.
- Counters: col counts 0..IMG_W-1. On wrap it returns to 0 and row increments. At (IMG_H-1, IMG_W-1) both return to 0.
- FSM:
  - FILL: row < K-1, no windows emitted.
  - STREAM: row >= K-1.
  - FILL -> STREAM on acc of pixel (K-2, IMG_W-1).
  - STREAM -> FILL on acc of the last pixel of the frame.
- Emit: on acc in STREAM with col >= K-1, out_valid goes high and out_window loads on the next edge (latency 1 cycle).
- Hold: out_valid and out_window stay stable until out_ready. On out_ready without a new emit, out_valid clears.
- frame_done: asserted with the window from pixel (IMG_H-1, IMG_W-1). It holds with out_valid and clears on handshake.
- Windows per frame: (IMG_H-K+1)*(IMG_W-K+1).
- Back-to-back frames:
  - No bubble between frames.
  - Stale line-buffer data from the previous frame is never emitted, because FILL suppresses output.
- Reset mid-frame: everything above is restored, any pending window is dropped, and the next accepted pixel is treated as (0,0).
- Simultaneous out_ready and new emit: the register reloads in the same cycle and out_valid stays 1.

Optional Feature:
- Macro: CONV_WINDOW_GEN_FRAME_CNT_EN.
- Defined:
  - Adds output frame_count [15:0], reset 0.
  - Increments on the acc of the last pixel of each frame; wraps 0xFFFF -> 0.
  - Reset mid-frame zeroes it.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package conv_pkg holds:
  - The window index function (r,c) -> bit offset.
  - Localparams for the counter widths, $clog2(IMG_W) and $clog2(IMG_H).
  - The FSM state enum {FILL, STREAM}.
- Sub-module conv_line_buf:
  - RAM-based delay of depth IMG_W.
  - Ports: shift-enable input, synchronous active-high reset of its internal pointer.
  - Instantiated K-1 times in a chain.

Test Plan:
1. IMG_W=4, IMG_H=4, K=3; feed data = 0..15 continuously with out_ready=1.
   - Exactly 4 windows, emitted after pixels 10, 11, 14, 15.
   - First window (r-major) = {0,1,2,4,5,6,8,9,10}.
   - Last window = {5,6,7,9,10,11,13,14,15}, with frame_done=1.
2. Same stream with out_ready=0 from the first window for 5 cycles.
   - in_ready=0 throughout; out_window is held at {0,1,2,4,5,6,8,9,10}.
   - Pixel 11 is not consumed.
   - After release, second window = {1,2,3,5,6,7,9,10,11}.
3. Two frames back-to-back, data 0..31.
   - Second frame's first window = {16,17,18,20,21,22,24,25,26}.
   - Total 8 windows; frame_done on the 4th and 8th.
4. Random in_valid gaps (about 50%), data 0..15.
   - Window sequence is identical to scenario 1; no window emitted on a non-accept cycle.
5. Reset asserted after pixel 9, then data 100..115.
   - No window containing 0..9 is emitted.
   - First window = {100,101,102,104,105,106,108,109,110}.
6. With CONV_WINDOW_GEN_FRAME_CNT_EN: three frames.
   - frame_count goes 0 -> 1 -> 2 -> 3, each step on a last-pixel accept.
   - Reset returns it to 0.
